// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and constants for the serial shifter family.
//               Direction encoding matches the existing parallel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    localparam logic DIR_LEFT  = 1'b1;   // MSB-first
    localparam logic DIR_RIGHT = 1'b0;   // LSB-first

endpackage : shift_pkg
`default_nettype wire

// File: rtl/out_buf_reg.sv
`default_nettype none
// ============================================================================
// Module      : out_buf_reg
// Description : One-word output buffer with valid/ready handshake.
//               A load is accepted when the buffer is empty or is being
//               consumed in the same cycle; otherwise the word is dropped and
//               'drop' is raised combinationally for the caller to flag.
// Ports       : clk, reset (async, active-low)
//               load / load_data : word offered by the assembler
//               out_ready        : consumer accepts out_data
//               out_data / out_valid : buffered word and its valid flag
//               drop             : offered word could not be stored
// Revision    : 1.0 - initial release
// ============================================================================
module out_buf_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             drop
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             can_load;

    always_comb begin
        can_load = !valid_q || out_ready;
        data_d   = data_q;
        valid_d  = valid_q;
        drop     = 1'b0;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            if (can_load) begin
                // A simultaneous consume and load keeps valid asserted.
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule : out_buf_reg
`default_nettype wire

// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : shift_deserializer
// Description : Serial-in / parallel-out receiver. Collects WIDTH bits,
//               MSB-first or LSB-first (direction latched with the start
//               bit), and hands completed words to a one-word output buffer.
// Ports       : clk, reset (async, active-low)
//               sin, sin_valid, start, dir : serial input and framing
//               out_data, out_valid, out_ready : parallel output handshake
//               busy      : frame partially received
//               overrun   : one-cycle pulse, word dropped (buffer full)
//               frame_err : one-cycle pulse, start seen mid-frame
// Revision    : 1.0 - initial release
// ============================================================================
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    deser_state_t     state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic             load;
    logic [WIDTH-1:0] load_word;
    logic             drop;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base,
                                                  input logic             d,
                                                  input logic             b);
        if (d == DIR_LEFT) begin
            return {base[WIDTH-2:0], b};
        end
        return {b, base[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        frame_err_d = 1'b0;
        load        = 1'b0;
        load_word   = shift_in(sr_q, dir_q, sin);

        if (sin_valid) begin
            if (start) begin
                // Start always (re)begins a frame; mid-frame it discards the
                // partial word and flags the framing error.
                frame_err_d = (state_q == SHIFT);
                dir_d       = dir;
                sr_d        = shift_in('0, dir, sin);
                cnt_d       = CNT_W'(1);
                state_d     = SHIFT;
            end else if (state_q == SHIFT) begin
                sr_d = load_word;
                if (cnt_q == LAST_CNT) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        overrun_d = drop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_LEFT;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    out_buf_reg #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_word),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .drop      (drop)
    );

    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule : shift_deserializer
`default_nettype wire

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-in/parallel-out receiver and the counterpart of the team's parallel shifter. It collects one bit per accepted cycle into a WIDTH-bit word, either MSB-first (left shift) or LSB-first (right shift). Completed words go into a one-word output buffer with a valid/ready handshake, so the next frame can shift in while the consumer stalls. Framing, overrun and framing-error detection are included.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; low clears all state
sin  input  1  serial data bit; sampled only when sin_valid=1
sin_valid  input  1  qualifies sin; one bit accepted per cycle when high
start  input  1  first-bit-of-frame marker; meaningful only with sin_valid=1
dir  input  1  1 = MSB-first (left shift), 0 = LSB-first (right shift); sampled with the start bit only
out_data  output  WIDTH  assembled word, held stable while out_valid=1 and out_ready=0
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data when out_valid && out_ready
busy  output  1  high while a frame is partially received (state SHIFT)
overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full
frame_err  output  1  one-cycle pulse: start seen mid-frame, so the partial word was discarded

Behaviour:
- Reset (reset=0, async): state=IDLE, shift reg=0, bit count=0, latched dir=1, out_data=0, out_valid=0, busy=0, overrun=0, frame_err=0.
- States:
  - IDLE: waits for a frame.
  - SHIFT: a frame is in progress and bit count is in 1..WIDTH-1.
- An accepted bit means sin_valid=1. Cycles with sin_valid=0 change nothing, and the frame may stall indefinitely.
- Shift rule, using the latched dir:
  - dir=1: sr <= {sr[WIDTH-2:0], sin}
  - dir=0: sr <= {sin, sr[WIDTH-1:1]}
  - After WIDTH bits, the first bit sits in the MSB (dir=1) or the LSB (dir=0).
- IDLE:
  - Accepted bit with start=1: latch dir, shift that bit into a zeroed sr, count=1, go to SHIFT.
  - Accepted bit with start=0: ignored, no flag raised.
- SHIFT, accepted bit with start=0: shift, count+1.
- SHIFT, accepted bit with start=1: pulse frame_err, restart the frame with this bit as bit 1 (re-latch dir, sr zeroed then shifted, count=1). Stay in SHIFT.
- Completion is the accepted bit that makes count=WIDTH, with start=0. On that same clock edge:
  - The full word goes to the output buffer, state goes to IDLE, count goes to 0.
  - Latency: out_valid is high in the cycle after the edge that sampled the last bit.
- Buffer load on completion:
  - Load if out_valid=0, or if out_valid=1 and out_ready=1 in the same cycle (old word consumed, new word loaded, out_valid stays 1).
  - If out_valid=1 and out_ready=0: new word dropped, overrun pulses, out_data unchanged.
- Handshake:
  - out_valid falls after a cycle with out_valid && out_ready, unless the same cycle also loads a new word.
  - out_data never changes while out_valid=1 and out_ready=0.
- busy = (state==SHIFT).
- overrun and frame_err are registered outputs that are high for exactly one cycle per event and otherwise 0.
- Reset asserted mid-frame or with a word pending: everything returns to reset values immediately and the pending word is lost.
- Bit counter width is $clog2(WIDTH+1). No wrap occurs, because the count returns to 0 at completion.

Decomposition:
- Package shift_pkg:
  - typedef enum logic {IDLE, SHIFT} deser_state_t
  - localparams DIR_LEFT=1'b1, DIR_RIGHT=1'b0
  - The existing shifter uses the same direction encoding.
- No sub-module is required. The output buffer (out_data/out_valid register with load/consume logic) may be a small sub-module, out_buf_reg, parameterized by WIDTH.

Test Plan:
- WIDTH=4, dir=1, bits 1,0,1,1 on consecutive cycles with start on the first bit, out_ready=1 -> out_data=4'b1011, out_valid high for exactly 1 cycle, busy high for 3 cycles.
- dir=0, bits 1,0,1,1 -> out_data=4'b1101. Then dir=1 on the next frame's start bit with bits 0,1,1,0 -> out_data=4'b0110.
- dir=1, bits 1,0,1,1 with sin_valid=0 gaps of 2 cycles between bits, and dir toggled during the gaps -> out_data=4'b1011, no flags.
- out_ready=0; send frame A=4'b1010 then frame B=4'b0101 -> out_data stays 4'b1010, overrun pulses once on B's last bit. Then raise out_ready -> A consumed, out_valid falls.
- Send bits 1,1, then start=1 with bits 0,0,1,1 -> frame_err pulses once, out_data=4'b0011.
- After 3 bits, pulse reset low mid-frame; then send a full frame 1,1,1,0 -> no output from the partial frame, out_data=4'b1110, all outputs at reset values while reset is low.
